// File: rtl/wb_arb_pkg.sv
// Shared encodings and default bus widths for the two-master Wishbone arbiter.
// The ABORT state only exists when WBARB_TIMEOUT_EN is defined.
package wb_arb_pkg;

  localparam int WB_AW_DEF = 16;
  localparam int WB_DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
`ifdef WBARB_TIMEOUT_EN
    , ABORT = 2'd3
`endif
  } arb_state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/wb_arb_timeout.sv
// Consecutive no-ack cycle counter for the arbiter; present only with WBARB_TIMEOUT_EN.
// o_expired fires combinationally on the TIMEOUT_CYCLES-th consecutive unacked cycle.
`ifdef WBARB_TIMEOUT_EN
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_count_en,
  input  logic i_ack,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    o_expired = i_count_en && !i_ack && (cnt_q == CNT_LAST);
    cnt_d     = cnt_q + 1'b1;
    if (!i_count_en || i_ack || o_expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter with one dead IDLE cycle per handoff.
// Defining WBARB_TIMEOUT_EN adds a no-ack timeout that errors the owner and parks in ABORT.
//
// state | meaning
// IDLE  | no owner; slave outputs 0, both masters stalled
// GNT_A | master A owns the slave until it drops i_a_cyc
// GNT_B | master B owns the slave until it drops i_b_cyc
// ABORT | timed-out owner held stalled until it drops its cyc
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW             = WB_AW_DEF,
  parameter int DW             = WB_DW_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_stall,
  output logic          o_a_ack,
  output logic          o_a_err,
  output logic [DW-1:0] o_a_data,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_stall,
  output logic          o_b_ack,
  output logic          o_b_err,
  output logic [DW-1:0] o_b_data,
  output logic          o_s_cyc,
  output logic          o_s_stb,
  output logic          o_s_we,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_data,
  input  logic          i_s_stall,
  input  logic          i_s_ack,
  input  logic          i_s_err,
  input  logic [DW-1:0] i_s_data
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  logic       gnt_a, gnt_b;
  logic       own_cyc;
  logic       tmo_expired;

  assign gnt_a = (state_q == GNT_A);
  assign gnt_b = (state_q == GNT_B);

`ifdef WBARB_TIMEOUT_EN
  owner_e abort_own_q, abort_own_d;

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_count_en((gnt_a || gnt_b) && own_cyc),
    .i_ack     (i_s_ack),
    .o_expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    own_cyc = 1'b0;
    case (state_q)
      GNT_A:   own_cyc = i_a_cyc;
      GNT_B:   own_cyc = i_b_cyc;
`ifdef WBARB_TIMEOUT_EN
      ABORT:   own_cyc = (abort_own_q == OWN_A) ? i_a_cyc : i_b_cyc;
`endif
      default: own_cyc = 1'b0;
    endcase
  end

  // last_owner only moves on contention; an uncontested grant leaves it alone
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
`ifdef WBARB_TIMEOUT_EN
    abort_own_d  = abort_own_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_a_cyc && i_b_cyc) begin
          if (last_owner_q == OWN_A) begin
            state_d      = GNT_B;
            last_owner_d = OWN_B;
          end else begin
            state_d      = GNT_A;
            last_owner_d = OWN_A;
          end
        end else if (i_a_cyc) begin
          state_d = GNT_A;
        end else if (i_b_cyc) begin
          state_d = GNT_B;
        end
      end
      GNT_A, GNT_B: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end
`ifdef WBARB_TIMEOUT_EN
        else if (tmo_expired) begin
          state_d     = ABORT;
          abort_own_d = gnt_a ? OWN_A : OWN_B;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_B;
`ifdef WBARB_TIMEOUT_EN
      abort_own_q  <= OWN_A;
`endif
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
`ifdef WBARB_TIMEOUT_EN
      abort_own_q  <= abort_own_d;
`endif
    end
  end

  // Responses are gated by the owner's cyc so a late ack after cyc drops is dropped
  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_addr = '0;
    o_s_data = '0;
    if (gnt_a) begin
      o_s_cyc  = i_a_cyc;
      o_s_stb  = i_a_stb;
      o_s_we   = i_a_we;
      o_s_addr = i_a_addr;
      o_s_data = i_a_data;
    end else if (gnt_b) begin
      o_s_cyc  = i_b_cyc;
      o_s_stb  = i_b_stb;
      o_s_we   = i_b_we;
      o_s_addr = i_b_addr;
      o_s_data = i_b_data;
    end
    if (tmo_expired || i_reset) begin
      o_s_cyc = 1'b0;
      o_s_stb = 1'b0;
    end

    o_a_stall = gnt_a ? i_s_stall : 1'b1;
    o_a_ack   = gnt_a && i_a_cyc && i_s_ack && !i_reset;
    o_a_err   = gnt_a && i_a_cyc && (i_s_err || tmo_expired) && !i_reset;
    o_a_data  = gnt_a ? i_s_data : '0;

    o_b_stall = gnt_b ? i_s_stall : 1'b1;
    o_b_ack   = gnt_b && i_b_cyc && i_s_ack && !i_reset;
    o_b_err   = gnt_b && i_b_cyc && (i_s_err || tmo_expired) && !i_reset;
    o_b_data  = gnt_b ? i_s_data : '0;
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the arbitration rules.
module tb_wb_rr_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_stall, a_ack, a_err, b_stall, b_ack, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_stall, s_ack, s_err;
  logic [DW-1:0] s_rdata;

  int checks = 0;
  int failures = 0;

  // model: owner 0=none 1=A 2=B; last 1=A 2=B
  int m_own, m_last, m_cnt;
  bit m_abort;

  logic          e_s_cyc, e_s_stb, e_s_we;
  logic [AW-1:0] e_s_addr;
  logic [DW-1:0] e_s_data;
  logic          e_a_stall, e_a_ack, e_a_err, e_b_stall, e_b_ack, e_b_err;
  logic [DW-1:0] e_a_data, e_b_data;

  wb_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data),
    .o_a_stall(a_stall), .o_a_ack(a_ack), .o_a_err(a_err), .o_a_data(a_rdata),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_b_stall(b_stall), .o_b_ack(b_ack), .o_b_err(b_err), .o_b_data(b_rdata),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_data(s_wdata),
    .i_s_stall(s_stall), .i_s_ack(s_ack), .i_s_err(s_err), .i_s_data(s_rdata)
  );

  function automatic bit owner_cyc();
    return (m_own == 1) ? bit'(a_cyc) : (m_own == 2) ? bit'(b_cyc) : 1'b0;
  endfunction

  function automatic bit timeout_now();
`ifdef WBARB_TIMEOUT_EN
    return (m_own != 0) && !m_abort && owner_cyc() && !s_ack && (m_cnt + 1 == TO);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_update();
    if (rst) begin
      m_own = 0; m_abort = 0; m_last = 2; m_cnt = 0;
    end else if (m_own == 0) begin
      m_cnt = 0;
      if (a_cyc && b_cyc) begin
        m_own  = (m_last == 1) ? 2 : 1;
        m_last = m_own;
      end else if (a_cyc) m_own = 1;
      else if (b_cyc) m_own = 2;
    end else if (!owner_cyc()) begin
      m_own = 0; m_abort = 0; m_cnt = 0;
    end else if (!m_abort) begin
      if (timeout_now()) begin
        m_abort = 1; m_cnt = 0;
      end else m_cnt = s_ack ? 0 : m_cnt + 1;
    end
  endtask

  task automatic model_outputs();
    bit tmo;
    tmo = timeout_now();
    e_s_cyc = 0; e_s_stb = 0; e_s_we = 0; e_s_addr = '0; e_s_data = '0;
    e_a_stall = 1; e_a_ack = 0; e_a_err = 0; e_a_data = '0;
    e_b_stall = 1; e_b_ack = 0; e_b_err = 0; e_b_data = '0;
    if (m_own == 1 && !m_abort) begin
      e_s_cyc = a_cyc && !tmo; e_s_stb = a_stb && !tmo; e_s_we = a_we;
      e_s_addr = a_addr; e_s_data = a_data;
      e_a_stall = s_stall; e_a_ack = a_cyc && s_ack;
      e_a_err = (a_cyc && s_err) || tmo; e_a_data = s_rdata;
    end else if (m_own == 2 && !m_abort) begin
      e_s_cyc = b_cyc && !tmo; e_s_stb = b_stb && !tmo; e_s_we = b_we;
      e_s_addr = b_addr; e_s_data = b_data;
      e_b_stall = s_stall; e_b_ack = b_cyc && s_ack;
      e_b_err = (b_cyc && s_err) || tmo; e_b_data = s_rdata;
    end
    if (rst) begin
      e_s_cyc = 0; e_s_stb = 0; e_a_ack = 0; e_a_err = 0; e_b_ack = 0; e_b_err = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic settle();
    #1;
    model_outputs();
  endtask

  task automatic clear_inputs();
    a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_data = '0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_data = '0;
    s_stall = 0; s_ack = 0; s_err = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    settle();
    checks++; if ({s_cyc, s_stb} !== 2'b00) begin failures++; $display("FAIL reset_slave_cyc_stb: got %b expected 00", {s_cyc, s_stb}); end
    checks++; if ({a_stall, b_stall} !== 2'b11) begin failures++; $display("FAIL reset_stalls: got %b expected 11", {a_stall, b_stall}); end
    checks++; if ({a_ack, b_ack, a_err, b_err} !== 4'b0000) begin failures++; $display("FAIL reset_ack_err: got %b expected 0000", {a_ack, b_ack, a_err, b_err}); end
    checks++; if ({s_we, s_addr, s_wdata} !== '0) begin failures++; $display("FAIL reset_slave_bus: got %h expected 0", {s_we, s_addr, s_wdata}); end
  endtask

  task automatic test_single();
    do_reset();
    a_cyc = 1; a_stb = 1; a_we = 1; a_addr = 16'h0000; a_data = 16'h0001;
    settle();
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL single_latency: o_s_cyc=%b expected 0", s_cyc); end
    tick(); settle();
    checks++; if ({s_cyc, s_stb, s_we, s_addr, s_wdata} !== {3'b111, 16'h0000, 16'h0001})
      begin failures++; $display("FAIL single_grant: got %h expected %h", {s_cyc, s_stb, s_we, s_addr, s_wdata}, {3'b111, 16'h0000, 16'h0001}); end
    s_ack = 1; s_rdata = 16'hBEEF; a_stb = 0;
    settle();
    checks++; if ({a_ack, a_rdata} !== {1'b1, 16'hBEEF}) begin failures++; $display("FAIL single_ack_route: got %h expected %h", {a_ack, a_rdata}, {1'b1, 16'hBEEF}); end
    checks++; if ({b_ack, b_stall, b_rdata} !== {2'b01, 16'h0000}) begin failures++; $display("FAIL single_nonowner: got %h expected %h", {b_ack, b_stall, b_rdata}, {2'b01, 16'h0000}); end
    tick();
    a_cyc = 0; s_ack = 1;
    settle();
    checks++; if ({a_ack, b_ack, s_cyc} !== 3'b000) begin failures++; $display("FAIL late_ack_dropped: got %b expected 000", {a_ack, b_ack, s_cyc}); end
    tick();
    s_ack = 0;
  endtask

  task automatic test_contention();
    do_reset();
    a_cyc = 1; a_stb = 1; a_addr = 16'h1111;
    b_cyc = 1; b_stb = 1; b_addr = 16'h2222;
    tick(); settle();
    checks++; if ({s_cyc, s_addr} !== {1'b1, 16'h1111}) begin failures++; $display("FAIL contend_first_a: got %h expected %h", {s_cyc, s_addr}, {1'b1, 16'h1111}); end
    tick(); tick(); settle();
    checks++; if ({s_addr, b_stall} !== {16'h1111, 1'b1}) begin failures++; $display("FAIL contend_hold_a: got %h expected %h", {s_addr, b_stall}, {16'h1111, 1'b1}); end
    a_cyc = 0; a_stb = 0;
    tick(); settle();
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL contend_dead_cycle: o_s_cyc=%b expected 0", s_cyc); end
    tick(); settle();
    checks++; if ({s_cyc, s_addr} !== {1'b1, 16'h2222}) begin failures++; $display("FAIL contend_then_b: got %h expected %h", {s_cyc, s_addr}, {1'b1, 16'h2222}); end
    b_cyc = 0; b_stb = 0;
    tick();
    a_cyc = 1; a_stb = 1; b_cyc = 1; b_stb = 1;
    tick(); settle();
    checks++; if ({s_cyc, s_addr} !== {1'b1, 16'h2222}) begin failures++; $display("FAIL contend_second_b: got %h expected %h", {s_cyc, s_addr}, {1'b1, 16'h2222}); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_stall();
    int stall_seen;
    do_reset();
    a_cyc = 1; a_stb = 1; a_we = 0; a_addr = 16'hA5A5; a_data = 16'h5A5A;
    tick();
    stall_seen = 0;
    for (int i = 0; i < 7; i++) begin
      s_stall = (i >= 1 && i <= 5);
      settle();
      if (a_stall === 1'b1) stall_seen++;
      checks++; if ({s_addr, s_wdata} !== {16'hA5A5, 16'h5A5A}) begin failures++; $display("FAIL stall_bus_stable[%0d]: got %h expected %h", i, {s_addr, s_wdata}, {16'hA5A5, 16'h5A5A}); end
      tick();
    end
    checks++; if (stall_seen != 5) begin failures++; $display("FAIL stall_cycles: got %0d expected 5", stall_seen); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    b_cyc = 1; b_stb = 1; b_addr = 16'h3333;
    tick(); tick();
    s_ack = 1; rst = 1;
    settle();
    checks++; if ({b_ack, b_err} !== 2'b00) begin failures++; $display("FAIL rstmid_during: got %b expected 00", {b_ack, b_err}); end
    tick();
    rst = 0;
    settle();
    checks++; if ({s_cyc, b_ack, b_err} !== 3'b000) begin failures++; $display("FAIL rstmid_after: got %b expected 000", {s_cyc, b_ack, b_err}); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_timeout();
    do_reset();
    a_cyc = 1; a_stb = 1; a_addr = 16'h0042;
    tick();
`ifdef WBARB_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      settle();
      checks++; if ({a_err, s_cyc} !== {k == 4, k != 4}) begin failures++; $display("FAIL timeout_cycle%0d: err_cyc=%b expected %b", k, {a_err, s_cyc}, {k == 4, k != 4}); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if ({s_cyc, a_err, a_stall} !== 3'b001) begin failures++; $display("FAIL timeout_abort%0d: got %b expected 001", k, {s_cyc, a_err, a_stall}); end
      tick();
    end
    a_cyc = 0; a_stb = 0;
    tick();
    a_cyc = 1; a_stb = 1;
    settle();
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL timeout_idle_latency: o_s_cyc=%b expected 0", s_cyc); end
    tick(); settle();
    checks++; if (s_cyc !== 1'b1) begin failures++; $display("FAIL timeout_regrant: o_s_cyc=%b expected 1", s_cyc); end
`else
    for (int k = 0; k < 300; k++) begin
      settle();
      checks++; if ({s_cyc, a_err} !== 2'b10) begin failures++; $display("FAIL notimeout_hold%0d: got %b expected 10", k, {s_cyc, a_err}); end
      tick();
    end
`endif
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) a_cyc = ~a_cyc;
      if ($urandom_range(0, 7) == 0) b_cyc = ~b_cyc;
      a_stb = a_cyc & $urandom_range(0, 1); b_stb = b_cyc & $urandom_range(0, 1);
      a_we = $urandom_range(0, 1); b_we = $urandom_range(0, 1);
      a_addr = AW'($urandom); b_addr = AW'($urandom);
      a_data = DW'($urandom); b_data = DW'($urandom);
      s_stall = ($urandom_range(0, 3) == 0); s_ack = ($urandom_range(0, 3) == 0);
      s_err = ($urandom_range(0, 15) == 0); s_rdata = DW'($urandom);
      rst = ($urandom_range(0, 127) == 0);
      settle();
      checks++; if ({s_cyc, s_stb, s_we, s_addr, s_wdata} !== {e_s_cyc, e_s_stb, e_s_we, e_s_addr, e_s_data})
        begin failures++; $display("FAIL rand_slave[%0d]: got %h expected %h", n, {s_cyc, s_stb, s_we, s_addr, s_wdata}, {e_s_cyc, e_s_stb, e_s_we, e_s_addr, e_s_data}); end
      checks++; if ({a_stall, a_ack, a_err, a_rdata} !== {e_a_stall, e_a_ack, e_a_err, e_a_data})
        begin failures++; $display("FAIL rand_master_a[%0d]: got %h expected %h", n, {a_stall, a_ack, a_err, a_rdata}, {e_a_stall, e_a_ack, e_a_err, e_a_data}); end
      checks++; if ({b_stall, b_ack, b_err, b_rdata} !== {e_b_stall, e_b_ack, e_b_err, e_b_data})
        begin failures++; $display("FAIL rand_master_b[%0d]: got %h expected %h", n, {b_stall, b_ack, b_err, b_rdata}, {e_b_stall, e_b_ack, e_b_err, e_b_data}); end
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    m_own = 0; m_abort = 0; m_last = 2; m_cnt = 0;
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
